// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds the pipeline while a divide runs.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                annul_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_o
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;     // |divisor|
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W:0]     shifted;
  logic                fits;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic                accept;

  // One restoring step; the shifted partial remainder needs DATA_W+1 bits.
  always_comb begin
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    fits     = (shifted >= {1'b0, dsr_q});
    diff     = shifted[DATA_W-1:0] - dsr_q;
    rem_step = fits ? diff : shifted[DATA_W-1:0];
    quo_step = {dvd_q[DATA_W-2:0], fits};
    rem_fix  = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    quo_fix  = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
  end

  always_comb begin
    a_abs  = (signed_i && a_i[DATA_W-1]) ? (~a_i + 1'b1) : a_i;
    b_abs  = (signed_i && b_i[DATA_W-1]) ? (~b_i + 1'b1) : b_i;
    accept = (state_q == StIdle) && start_i && !annul_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (b_i == '0) begin
            // Divide by zero completes at once with a fixed, trap-free result.
            result_d = {a_i, {DATA_W{1'b1}}};
            state_d  = StDone;
          end else begin
            dvd_d     = a_abs;
            dsr_d     = b_abs;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = signed_i && (a_i[DATA_W-1] != b_i[DATA_W-1]);
            neg_rem_d = signed_i && a_i[DATA_W-1];
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (annul_i) begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = StIdle;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            result_d = {rem_fix, quo_fix};
            cnt_d    = '0;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    result_o = result_q;
    ready_o  = (state_q == StDone);
    stall_o  = (accept && !rst) || (state_q == StBusy);
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: unsigned/signed cases, divide by zero, annul,
// mid-operation reset and back-to-back requests.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request for a single cycle, scramble operands after acceptance,
  // then wait for ready_o and check latency, stall and result.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int exp_lat);
    int   n;
    logic stall_ok;
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    #1;
    check({tag, " stall_req"}, 64'(stall_o), 64'd1);
    tick();
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; signed_i = ~s;
    n = 0;
    stall_ok = 1'b1;
    while (!ready_o && n < 100) begin
      if (!stall_o) stall_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " ready"}, 64'(ready_o), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp);
    check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, " stall_done"}, 64'(stall_o), 64'd0);
    tick();
    check({tag, " ready_pulse"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int   n;
    logic seen;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    a_i = '0; b_i = '0;
    tick(); tick();
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    start_i = 1'b1;
    #1;
    check("reset stall with start", 64'(stall_o), 64'd0);
    start_i = 1'b0;
    rst = 1'b0;
    tick();
    check("idle stall", 64'(stall_o), 64'd0);

    run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 32);
    run_div("div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 32);
    run_div("div 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 32);
    run_div("div min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 32);
    run_div("divu min/max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 32);
    run_div("div 5/0", 32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, 0);
    run_div("divu 5/0", 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 0);

    // Annul at BUSY step 10.
    a_i = 32'd1000; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul stall", 64'(stall_o), 64'd0);
    check("annul result", result_o, 64'h00000005_FFFFFFFF);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen = 1'b1;
      tick();
    end
    check("annul no ready", 64'(seen), 64'd0);
    run_div("divu 1000/7", 32'd1000, 32'd7, 1'b0, 64'h00000006_0000008E, 32);

    // Annul together with start in IDLE: request is refused.
    a_i = 32'd9; b_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    #1;
    check("annul idle stall", 64'(stall_o), 64'd0);
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || stall_o) seen = 1'b1;
      tick();
    end
    check("annul idle no accept", 64'(seen), 64'd0);
    check("annul idle result", result_o, 64'h00000006_0000008E);

    // Reset in the middle of a divide.
    a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst result", result_o, 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst stall", 64'(stall_o), 64'd0);
    run_div("divu 100/7 after rst", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 32);

    // start_i held high across two back-to-back divides.
    a_i = 32'd20; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    tick();
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    check("b2b first latency", 64'(n), 64'd32);
    check("b2b first result", result_o, 64'h00000002_00000006);
    a_i = 32'd9; b_i = 32'd4;
    tick();
    check("b2b gap ready", 64'(ready_o), 64'd0);
    check("b2b gap stall", 64'(stall_o), 64'd1);
    tick();
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    check("b2b second latency", 64'(n), 64'd32);
    check("b2b second result", result_o, 64'h00000001_00000002);
    start_i = 1'b0;
    tick();
    check("b2b second pulse", 64'(ready_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
